// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with iterative shift/multiply and registered flags.
// Ports: clk, rst_n, in_valid/in_ready/in1/in2/func/neg, out/out_valid/out_ready, flags {N,V,C,Z}.
module alu_seq #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       func,
  input  logic             neg,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       flags
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [WIDTH-1:0] WMAX = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   KMAX = SHW'(WIDTH);

  logic [1:0]         state;
  logic [2:0]         op;
  logic               inv;
  logic [WIDTH-1:0]   a;
  logic [2*WIDTH-1:0] acc;
  logic [SHW-1:0]     cnt;
  logic               cy;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Final result and flags; C and V come from the raw operation.
  function automatic logic [WIDTH+3:0] fin(
    input logic [WIDTH-1:0] r,
    input logic             n,
    input logic             c,
    input logic             v
  );
    logic [WIDTH-1:0] o;
    o = r ^ {WIDTH{n}};
    return {o, o[WIDTH-1], v, c, (o == '0)};
  endfunction

  // Accept-time result: single-cycle ops, and zero-length shifts (raw = in1).
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH-1:0] raw1;
  logic             c1;
  logic             v1;
  logic [SHW-1:0]   k;

  always_comb begin
    add_s = {1'b0, in1} + {1'b0, in2};
    sub_s = {1'b0, in1} + {1'b0, ~in2} + (WIDTH+1)'(1);
    k     = (in2 < WMAX) ? SHW'(in2) : KMAX;
    raw1  = in1;
    c1    = 1'b0;
    v1    = 1'b0;
    case (func)
      OP_ADD: begin
        raw1 = add_s[WIDTH-1:0];
        c1   = add_s[WIDTH];
        v1   = (in1[WIDTH-1] == in2[WIDTH-1]) &&
               (add_s[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        raw1 = sub_s[WIDTH-1:0];
        c1   = sub_s[WIDTH];
        v1   = (in1[WIDTH-1] != in2[WIDTH-1]) &&
               (sub_s[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND:  raw1 = in1 & in2;
      OP_OR:   raw1 = in1 | in2;
      OP_XOR:  raw1 = in1 ^ in2;
      default: raw1 = in1;
    endcase
  end

  // One iteration step. Shifts work in acc's low half; mul uses all of acc
  // as {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     mul_s;
  logic [2*WIDTH-1:0] acc_n;
  logic               cy_n;

  always_comb begin
    mul_s = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a} : '0);
    acc_n = acc;
    cy_n  = cy;
    case (op)
      OP_SHL: begin
        acc_n = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
        cy_n  = acc[WIDTH-1];
      end
      OP_SHR: begin
        acc_n = {acc[2*WIDTH-1:WIDTH], 1'b0, acc[WIDTH-1:1]};
        cy_n  = acc[0];
      end
      OP_MUL: begin
        acc_n = {mul_s, acc[WIDTH-1:1]};
        cy_n  = |acc_n[2*WIDTH-1:WIDTH];
      end
      default: begin
        acc_n = acc;
        cy_n  = cy;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op    <= '0;
      inv   <= 1'b0;
      a     <= '0;
      acc   <= '0;
      cnt   <= '0;
      cy    <= 1'b0;
      out   <= '0;
      flags <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op  <= func;
            inv <= neg;
            a   <= in1;
            cy  <= 1'b0;
            if (func == OP_MUL) begin
              acc   <= {{WIDTH{1'b0}}, in2};
              cnt   <= KMAX;
              state <= BUSY;
            end else if ((func == OP_SHL || func == OP_SHR) && k != '0) begin
              acc   <= {{WIDTH{1'b0}}, in1};
              cnt   <= k;
              state <= BUSY;
            end else begin
              {out, flags} <= fin(raw1, neg, c1, v1);
              state        <= DONE;
            end
          end
        end
        BUSY: begin
          acc <= acc_n;
          cy  <= cy_n;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            {out, flags} <= fin(acc_n[WIDTH-1:0], inv, cy_n, 1'b0);
            state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
